cal1d_fp16_pool_sum_ctrl: RTL
=============================

# cal1d_fp16_pool_sum_ctrl

Window-sequencing controller for the 4-lane fp17 1D pooling sum unit in PDP. It accepts a stream of 4-lane fp17 vectors and folds each window of K consecutive vectors into one running sum. Each fold is issued as one add to the external sum unit: a = new element, b = partial sum. It emits one summed vector per window and sits between the PDP 1D pooling input pipe and the sum unit. The sum unit's ready/valid channels are driven directly.

## Interface
- (no parameters) — lane width 17 and lane count 4 are fixed; packed vectors carry lane i at bits [17i+16:17i].
- nvdla_core_clk  in  1  clock (connect to the fp16 op-gated clock).
- nvdla_core_rstn  in  1  reset; asynchronous, active-low.
- reg2dp_kernel_width  in  3  window size minus 1 (0..7 → K = 1..8); sampled only when a window's first element is accepted.
- pool_in_pvld  in  1  input vector valid.
- pool_in_prdy  out  1  input vector ready.
- pool_in_pd  in  68  input vector.
- sum_in_pvld  out  1  add request valid to sum unit (both operands).
- sum_in_prdy  in  1  sum unit accepts operands.
- sum_a_pd  out  68  operand a (= pool_in_pd).
- sum_b_pd  out  68  operand b (= partial sum register).
- sum_out_pvld  in  1  sum unit result valid.
- sum_out_prdy  out  1  controller accepts result.
- sum_z_pd  in  68  sum unit result.
- pool_out_pvld  out  1  window result valid.
- pool_out_prdy  in  1  downstream ready.
- pool_out_pd  out  68  window result (= partial sum register).
- ctrl_busy  out  1  high whenever state != IDLE.

## Operation
- Registers:
  - state (IDLE, ACC, WAIT, OUT).
  - partial[67:0].
  - cnt[2:0]: elements folded minus 1.
  - kw[2:0]: latched window size.
- IDLE:
  - pool_in_prdy = 1.
  - On accept: partial ← pool_in_pd, cnt ← 0, kw ← reg2dp_kernel_width; next = OUT if reg2dp_kernel_width == 0, else ACC.
  - No add is issued for the first element.
- ACC:
  - sum_in_pvld = pool_in_pvld.
  - pool_in_prdy = sum_in_prdy.
  - sum_a_pd = pool_in_pd, sum_b_pd = partial.
  - Input and add-request handshakes are the same event; on it, next = WAIT.
- WAIT:
  - sum_out_prdy = 1; pool_in_prdy = 0; sum_in_pvld = 0.
  - On sum_out_pvld: partial ← sum_z_pd, cnt ← cnt + 1; next = OUT if cnt + 1 == kw, else ACC.
  - Exactly one add is in flight at any time (data dependence on partial).
- OUT:
  - pool_out_pvld = 1, pool_out_pd = partial.
  - On pool_out_prdy alone: next = IDLE.
  - Simultaneous pool_out_prdy & pool_in_pvld: pool_in_prdy = pool_out_prdy, and the new first element is loaded exactly as in IDLE (back-to-back windows, no bubble).
- Outside WAIT, sum_out_prdy = 0; a sum_out_pvld arriving then is ignored.
- Outside ACC, sum_in_pvld = 0.
- sum_a_pd/sum_b_pd are driven continuously; they are don't-care when sum_in_pvld = 0.
- Controller is format-agnostic: it never inspects lane bits.
- Changing reg2dp_kernel_width mid-window has no effect until the next first-element accept.

## Timing
- Reset: state = IDLE, partial = 0, cnt = 0, kw = 0; outputs pool_in_prdy = 1, sum_in_pvld = 0, sum_out_prdy = 0, pool_out_pvld = 0, ctrl_busy = 0.
- Reset mid-window: the partial sum and any in-flight add are discarded (the sum unit shares reset); the next accepted element starts a new window.
- K = 1: first element accepted in cycle t; pool_out_pvld high in t+1.
- K > 1, sum-unit result latency L cycles after operand handshake, all readies high:
  - Each fold costs L + 1 cycles (ACC handshake cycle + L WAIT cycles, counting the result cycle).
  - pool_out_pvld asserts 1 + (K−1)(L+1) cycles after the first-element accept.
- All outputs are combinational functions of state and handshake inputs.
- No combinational path from sum_out_pvld to sum_in_pvld.
- pool_out_pd is stable while pool_out_pvld is high and pool_out_prdy is low.

## Test plan
- Bench model: sum unit returns lane-wise integer sums with L = 3; downstream ready always high unless stated.
- K=1 (kernel_width=0), inputs lanes {1,2,3,4} then {5,6,7,8} → outputs {1,2,3,4}, {5,6,7,8}; zero add requests; second accept in the same cycle as the first output handshake.
- K=3, inputs lanes all 1, 2, 3 → one output, all lanes 6; exactly 2 add requests with b = {1,…} then {3,…}; pool_out_pvld 9 cycles after the first accept.
- K=8 with sum_in_prdy randomly low 50% and pool_out_prdy held low 5 cycles → output = sum of the 8 inputs; pool_out_pd stable while stalled; pool_in_prdy low throughout stall.
- kernel_width changed 2→4 after the first element of a window → that window closes at 3 elements; the next window closes at 5.
- Assert nvdla_core_rstn low while in WAIT (add in flight) → next cycle all reset values; a spurious sum_out_pvld pulse after reset is not consumed (sum_out_prdy = 0); the next window of K=2, inputs {10,…},{20,…} → output {30,…}.

Source files
------------

// File: rtl/cal1d_fp16_pool_sum_ctrl.sv
// cal1d_fp16_pool_sum_ctrl: folds windows of K 4-lane fp17 vectors through an external sum unit
module cal1d_fp16_pool_sum_ctrl (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rstn,
  input  logic [2:0]  reg2dp_kernel_width,
  input  logic        pool_in_pvld,
  output logic        pool_in_prdy,
  input  logic [67:0] pool_in_pd,
  output logic        sum_in_pvld,
  input  logic        sum_in_prdy,
  output logic [67:0] sum_a_pd,
  output logic [67:0] sum_b_pd,
  input  logic        sum_out_pvld,
  output logic        sum_out_prdy,
  input  logic [67:0] sum_z_pd,
  output logic        pool_out_pvld,
  input  logic        pool_out_prdy,
  output logic [67:0] pool_out_pd,
  output logic        ctrl_busy
);
  typedef enum logic [1:0] {IDLE, ACC, WAIT, OUT} state_t;
  state_t      state;
  logic [67:0] partial;
  logic [2:0]  cnt, kw, cnt_nxt;
  logic        in_acc;
  always_comb begin
    pool_in_prdy  = state == IDLE ? 1'b1 : state == ACC ? sum_in_prdy : state == OUT ? pool_out_prdy : 1'b0;
    sum_in_pvld   = state == ACC && pool_in_pvld;
    sum_out_prdy  = state == WAIT;
    pool_out_pvld = state == OUT;
    ctrl_busy     = state != IDLE;
    sum_a_pd      = pool_in_pd;
    sum_b_pd      = partial;
    pool_out_pd   = partial;
    in_acc        = pool_in_pvld && pool_in_prdy;
    cnt_nxt       = cnt + 3'd1;
  end
  // OUT shares the first-element load with IDLE so back-to-back windows have no bubble
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state   <= IDLE;
      partial <= '0;
      cnt     <= '0;
      kw      <= '0;
    end else begin
      case (state)
        IDLE, OUT: begin
          if (in_acc) begin
            partial <= pool_in_pd;
            cnt     <= '0;
            kw      <= reg2dp_kernel_width;
            state   <= reg2dp_kernel_width == 3'd0 ? OUT : ACC;
          end else if (state == OUT && pool_out_prdy) state <= IDLE;
        end
        ACC: if (in_acc) state <= WAIT;
        WAIT: begin
          if (sum_out_pvld) begin
            partial <= sum_z_pd;
            cnt     <= cnt_nxt;
            state   <= cnt_nxt == kw ? OUT : ACC;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
